// File: rtl/bsearch_fsm.sv
// Binary-search sequencer: latches a target, walks l/r pointers over a sorted
// synchronous-read RAM, and reports found/loc with a done flag.
module bsearch_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] loc
);

  localparam int unsigned SUM_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [ADDR_WIDTH-1:0] l_q, l_d;
  logic [ADDR_WIDTH-1:0] r_q, r_d;
  logic                  done_q, done_d;
  logic                  found_q, found_d;
  logic [ADDR_WIDTH-1:0] loc_q, loc_d;

  logic [SUM_WIDTH-1:0]  sum;
  logic [ADDR_WIDTH-1:0] mid;

  // Midpoint from a widened sum so l+r cannot overflow.
  always_comb begin
    sum = SUM_WIDTH'(l_q) + SUM_WIDTH'(r_q);
    mid = ADDR_WIDTH'(sum >> 1);
  end

  // Pointers are frozen in S_ADDR, so the address holds into S_CMP.
  always_comb begin
    ram_addr = '0;
    if ((state_q == S_ADDR) || (state_q == S_CMP)) begin
      ram_addr = mid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      l_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      loc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      l_q     <= l_d;
      r_q     <= r_d;
      done_q  <= done_d;
      found_q <= found_d;
      loc_q   <= loc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    l_d     = l_q;
    r_d     = r_q;
    found_d = found_q;
    loc_d   = loc_q;

    unique case (state_q)
      S_IDLE: begin
        if (s) begin
          a_d     = in;
          l_d     = '0;
          r_d     = ADDR_MAX;
          found_d = 1'b0;
          loc_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        // Edge checks on mid==r / mid==l keep the pointers from wrapping.
        if (a_q == ram_rdata) begin
          found_d = 1'b1;
          loc_d   = mid;
          state_d = S_DONE;
        end else if (a_q > ram_rdata) begin
          if (mid == r_q) begin
            state_d = S_DONE;
          end else begin
            l_d     = mid + ADDR_ONE;
            state_d = S_ADDR;
          end
        end else begin
          if (mid == l_q) begin
            state_d = S_DONE;
          end else begin
            r_d     = mid - ADDR_ONE;
            state_d = S_ADDR;
          end
        end
      end
      S_DONE: begin
        if (!s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  assign done  = done_q;
  assign found = found_q;
  assign loc   = loc_q;

endmodule

// File: tb/tb_bsearch_fsm.sv
// Directed and random searches over a RAM holding mem[i]=2*i+1, checked
// against a behavioural model of the search result and its latency.
module tb_bsearch_fsm;

  logic       clk;
  logic       reset;
  logic       s;
  logic [7:0] in;
  logic [7:0] ram_rdata;
  logic [4:0] ram_addr;
  logic       done;
  logic       found;
  logic [4:0] loc;

  int checks;
  int failures;

  logic [7:0] mem [0:31];

  bsearch_fsm #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .in       (in),
    .ram_rdata(ram_rdata),
    .ram_addr (ram_addr),
    .done     (done),
    .found    (found),
    .loc      (loc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit ref_found(input int t);
    return (t % 2 == 1) && (t >= 1) && (t <= 63);
  endfunction

  function automatic int ref_loc(input int t);
    return ref_found(t) ? (t - 1) / 2 : 0;
  endfunction

  // Probe count of a textbook binary search over the values 2*i+1.
  function automatic int ref_probes(input int t);
    int lo = 0;
    int hi = 31;
    int k  = 0;
    int m;
    while (k < 64) begin
      m = (lo + hi) / 2;
      k++;
      if (2 * m + 1 == t) return k;
      if (t > 2 * m + 1) begin
        if (m == hi) return k;
        lo = m + 1;
      end else begin
        if (m == lo) return k;
        hi = m - 1;
      end
    end
    return k;
  endfunction

  // Start a search, optionally dropping s right after acceptance; check latency,
  // address stability between address/compare cycles, and the result.
  task automatic run(input int t, input bit drop_s, input string tag);
    int n;
    logic [4:0] prev_addr;
    @(negedge clk);
    in = 8'(t);
    s  = 1'b1;
    @(posedge clk);
    n = 0;
    prev_addr = '0;
    do begin
      @(negedge clk);
      n++;
      if (drop_s) s = 1'b0;
      in = 8'($urandom);
      if (!done) begin
        if (n % 2 == 1) prev_addr = ram_addr;
        else check({tag, "_addr_stable"}, 32'(ram_addr), 32'(prev_addr));
      end
    end while (!done && n < 40);
    check({tag, "_latency"}, 32'(n), 32'(2 * ref_probes(t) + 1));
    check({tag, "_found"}, 32'(found), 32'(ref_found(t)));
    check({tag, "_loc"}, 32'(loc), 32'(ref_loc(t)));
    check({tag, "_addr_idle"}, 32'(ram_addr), 32'd0);
    if (drop_s) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_found_held"}, 32'(found), 32'(ref_found(t)));
      check({tag, "_loc_held"}, 32'(loc), 32'(ref_loc(t)));
    end
  endtask

  task automatic release_s(input string tag);
    @(negedge clk);
    s = 1'b0;
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int t;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i + 1);
    reset = 1'b1;
    s     = 1'b0;
    in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_loc", 32'(loc), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;

    run(31, 1'b0, "t31");
    release_s("t31");
    run(21, 1'b0, "t21");
    release_s("t21");
    run(1, 1'b0, "t1");
    release_s("t1");
    run(63, 1'b0, "t63");
    release_s("t63");
    run(0, 1'b0, "t0");
    release_s("t0");
    run(64, 1'b0, "t64");
    release_s("t64");
    run(22, 1'b0, "t22");
    release_s("t22");

    // Hold s after completion: result must stay put.
    run(9, 1'b0, "hold");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("hold_done", 32'(done), 32'd1);
      check("hold_found", 32'(found), 32'd1);
      check("hold_loc", 32'(loc), 32'd4);
    end
    release_s("hold");
    @(negedge clk);
    check("idle_found_held", 32'(found), 32'd1);
    check("idle_loc_held", 32'(loc), 32'd4);
    run(41, 1'b0, "t41");
    release_s("t41");

    run(21, 1'b1, "drop21");

    // Reset during a compare cycle.
    @(negedge clk);
    in = 8'd21;
    s  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rcmp_done", 32'(done), 32'd0);
    check("rcmp_found", 32'(found), 32'd0);
    check("rcmp_loc", 32'(loc), 32'd0);
    check("rcmp_addr", 32'(ram_addr), 32'd0);
    run(51, 1'b0, "t51");

    // Reset in the done state clears a held result.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s = 1'b0;
    check("rdone_done", 32'(done), 32'd0);
    check("rdone_found", 32'(found), 32'd0);
    check("rdone_loc", 32'(loc), 32'd0);
    @(negedge clk);
    check("rdone_idle", 32'(done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(0, 255));
      if (i % 2 == 0) t = int'($urandom_range(0, 31)) * 2 + 1;
      run(t, (i % 5 == 0), "rand");
      if (i % 5 != 0) release_s("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
